dct_transpose_buffer: RTL
=========================

Name: dct_transpose_buffer

Overview:
- Sits between the row-pass and column-pass 1-D DCT stages of the 2-D DCT.
- Captures 8 parallel row-transform results per row_done pulse. After 8 rows (one 8x8 block), streams the block out serially in column-major order to feed the column-pass stage.
- Ping-pong banks let one block fill while the previous block drains.

Parameters:
- W, 12, width of each row coefficient and of Xout (matches row-stage output width 2*8-4).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- row_valid  input  1  one-cycle strobe; Y0..Y7 hold a complete transformed row (driven by row_done).
- Y0..Y7  input  W each  row coefficients, signed two's complement.
- Xout  output  W  serial coefficient for the column pass.
- out_valid  output  1  Xout valid this cycle.
- col_start  output  1  high with the first sample (row 0) of each column.
- out_col  output  3  column index of the current Xout.
- block_done  output  1  high with the 64th sample of a block.
- overflow  output  1  sticky row-dropped flag (see Optional Feature).

Behaviour:
- Storage: two banks, each 8x8 words of W bits. Memory contents are not reset.
- Per-bank flags: full[0], full[1].
- Write side: wr_bank, wr_row (0..7).
  - On row_valid with full[wr_bank]==0: bank[wr_bank][wr_row][k] <= Yk for k=0..7; wr_row increments.
  - When wr_row==7 on that write: set full[wr_bank], wr_row wraps to 0, wr_bank toggles.
  - On row_valid with full[wr_bank]==1: row dropped, no pointer change, overflow event.
- Read FSM states: IDLE, STREAM.
  - IDLE: if full[rd_bank], next edge go to STREAM with rd_r=0, rd_c=0.
  - STREAM: each edge registers Xout <= bank[rd_bank][rd_r][rd_c], out_valid=1, out_col=rd_c, col_start=(rd_r==0). Then rd_r increments; on wrap rd_c increments.
  - On the 64th sample (rd_r==7, rd_c==7): block_done=1, full[rd_bank] cleared, rd_bank toggles, FSM returns to IDLE.
- Output order: bank[0][0], bank[1][0], …, bank[7][0], bank[0][1], … bank[7][7].
- Latency: write of row 7 at edge E. FSM enters STREAM at E+1. First Xout visible after E+2. Then 64 consecutive valid cycles with no gaps inside a block.
- Block-to-block: one bubble cycle (IDLE) minimum between blocks.
- Idle outputs: out_valid, col_start, block_done = 0; Xout and out_col hold their last values.
- Simultaneous full-clear and row_valid to the same bank on one edge: the clear wins, the row is accepted, no overflow.
- All outputs are registered. No arithmetic, width unchanged, sign preserved bit-exact.
- Reset (asynchronous, any time, including mid-stream): state IDLE, wr_bank=rd_bank=0, wr_row=rd_r=rd_c=0, full=0. Outputs: Xout=0, out_valid=0, col_start=0, out_col=0, block_done=0, overflow=0.
  - A partially written or partially read block is discarded.

Optional Feature:
- Macro TRANSPOSE_OVF_EN.
- Defined: overflow sets on any dropped row and stays set until reset.
- Undefined: overflow is tied to 0. Dropped rows are still silently discarded.

Test Plan:
- Basic transpose: 8 row_valid pulses every 8 cycles, row r carries Yk=8r+k.
  - Required: 64 consecutive out_valid samples 0,8,16,…,56,1,9,…,63.
  - col_start on samples 0,8,…,56; block_done on value 63; first sample 2 cycles after the 8th row_valid edge.
- Negative data: Y values −1 (all ones) and −2048 (0x800).
  - Required: output bit-identical, sign intact.
- Back-to-back blocks: 16 rows with 8-cycle spacing, second block values +100.
  - Required: block 1 streams while block 2 fills. Block 2 output begins one bubble after block 1 block_done. Overflow stays 0.
- Overflow: 24 rows at 1-cycle spacing.
  - Required: rows 17–24 dropped; overflow=1 with TRANSPOSE_OVF_EN, 0 without.
  - First two blocks are output correctly.
- Simultaneous release: a row_valid targeting bank 0 on the same edge as bank 0 block_done.
  - Required: row accepted as row 0 of the new block, no overflow.
- Reset mid-stream: assert reset at sample 20 of a block.
  - Required: outputs zero immediately, asynchronously.
  - After release, a fresh 8-row block is output correctly from row 0/col 0.

Source files
------------

// File: rtl/dct_transpose_buffer.sv
// -----------------------------------------------------------------------------
// dct_transpose_buffer
//
// Sits between the row pass and the column pass of a 2-D 8x8 DCT. Each
// row_valid strobe captures one complete row of eight coefficients. Once a
// block of eight rows is complete, it is streamed out one coefficient per
// cycle in column-major order. Two ping-pong banks allow one block to fill
// while the previous block drains.
//
// Optional feature macro: TRANSPOSE_OVF_EN
//   defined   : overflow is a sticky flag, set whenever a row is dropped
//               because the target bank still holds an undrained block.
//   undefined : overflow is held at 0. Dropped rows are discarded silently.
//
// The storage is split into one small memory per column. A row write then
// touches every column memory at the same address, and a read selects a
// single column memory. Memory contents are not reset.
// -----------------------------------------------------------------------------
module dct_transpose_buffer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         row_valid,
    input  logic [W-1:0] Y0,
    input  logic [W-1:0] Y1,
    input  logic [W-1:0] Y2,
    input  logic [W-1:0] Y3,
    input  logic [W-1:0] Y4,
    input  logic [W-1:0] Y5,
    input  logic [W-1:0] Y6,
    input  logic [W-1:0] Y7,
    output logic [W-1:0] Xout,
    output logic         out_valid,
    output logic         col_start,
    output logic [2:0]   out_col,
    output logic         block_done,
    output logic         overflow
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Incoming row gathered into an array so the column memories can be generated
    logic [W-1:0] y_row [8];

    assign y_row[0] = Y0;
    assign y_row[1] = Y1;
    assign y_row[2] = Y2;
    assign y_row[3] = Y3;
    assign y_row[4] = Y4;
    assign y_row[5] = Y5;
    assign y_row[6] = Y6;
    assign y_row[7] = Y7;

    // Write-side state
    logic       wr_bank_q, wr_bank_d;
    logic [2:0] wr_row_q,  wr_row_d;
    logic [1:0] full_q,    full_d;

    // Read-side state
    state_t     state_q,   state_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] rd_r_q,    rd_r_d;
    logic [2:0] rd_c_q,    rd_c_d;

    // Registered outputs
    logic [W-1:0] xout_q,       xout_d;
    logic         out_valid_q,  out_valid_d;
    logic         col_start_q,  col_start_d;
    logic [2:0]   out_col_q,    out_col_d;
    logic         block_done_q, block_done_d;
    logic         overflow_q,   overflow_d;

    // Handshake between the two sides
    logic         clear_now;
    logic         bank_free;
    logic         wr_en;
    logic [W-1:0] col_rd [8];

    // The last sample of a block releases its bank on this very edge
    assign clear_now = (state_q == S_STREAM) && (rd_r_q == 3'd7) && (rd_c_q == 3'd7);

    // A bank being released on this edge may be refilled on the same edge
    assign bank_free = !full_q[wr_bank_q] || (clear_now && (rd_bank_q == wr_bank_q));
    assign wr_en     = row_valid && bank_free;

`ifdef TRANSPOSE_OVF_EN
    logic row_drop;
    assign row_drop = row_valid && !bank_free;
`endif

    // One memory per column, addressed by {bank, row}
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_col
            logic [W-1:0] col_mem [16];

            // Capture coefficient gi of the incoming row
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    col_mem[{wr_bank_q, wr_row_q}] <= y_row[gi];
                end
            end

            assign col_rd[gi] = col_mem[{rd_bank_q, rd_r_q}];
        end
    endgenerate

    // Write pointer advance, bank full flags and the overflow flag
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        full_d    = full_q;

        if (clear_now) begin
            full_d[rd_bank_q] = 1'b0;
        end

        if (wr_en) begin
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_row_d          = 3'd0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_row_d = wr_row_q + 3'd1;
            end
        end

`ifdef TRANSPOSE_OVF_EN
        overflow_d = overflow_q | row_drop;
`else
        overflow_d = 1'b0;
`endif
    end

    // Read FSM: wait for a full bank, then walk it column by column
    always_comb begin
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        rd_r_d       = rd_r_q;
        rd_c_d       = rd_c_q;
        xout_d       = xout_q;
        out_col_d    = out_col_q;
        out_valid_d  = 1'b0;
        col_start_d  = 1'b0;
        block_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = S_STREAM;
                    rd_r_d  = 3'd0;
                    rd_c_d  = 3'd0;
                end
            end

            S_STREAM: begin
                xout_d      = col_rd[rd_c_q];
                out_valid_d = 1'b1;
                out_col_d   = rd_c_q;
                col_start_d = (rd_r_q == 3'd0);
                rd_r_d      = rd_r_q + 3'd1;
                if (rd_r_q == 3'd7) begin
                    rd_c_d = rd_c_q + 3'd1;
                    if (rd_c_q == 3'd7) begin
                        block_done_d = 1'b1;
                        rd_bank_d    = ~rd_bank_q;
                        state_d      = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_bank_q    <= 1'b0;
            wr_row_q     <= 3'd0;
            full_q       <= 2'b00;
            rd_bank_q    <= 1'b0;
            rd_r_q       <= 3'd0;
            rd_c_q       <= 3'd0;
            xout_q       <= '0;
            out_valid_q  <= 1'b0;
            col_start_q  <= 1'b0;
            out_col_q    <= 3'd0;
            block_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            wr_row_q     <= wr_row_d;
            full_q       <= full_d;
            rd_bank_q    <= rd_bank_d;
            rd_r_q       <= rd_r_d;
            rd_c_q       <= rd_c_d;
            xout_q       <= xout_d;
            out_valid_q  <= out_valid_d;
            col_start_q  <= col_start_d;
            out_col_q    <= out_col_d;
            block_done_q <= block_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign Xout       = xout_q;
    assign out_valid  = out_valid_q;
    assign col_start  = col_start_q;
    assign out_col    = out_col_q;
    assign block_done = block_done_q;
    assign overflow   = overflow_q;

endmodule
